emitter_uart: RTL and testbench
===============================

# emitter_uart

Transmit-only 8N1 UART serializer for the SoC's memory-mapped UART data register. A one-cycle write strobe from the bus presents a byte. The block shifts it out on a single TX line at a fixed baud rate of clock/`clk_divider` and reports busy status, which the SoC exposes to software as status bit 9 (`!o_ready`). It has no receive path and no FIFO: one byte is in flight at a time.

## Interface
- `clk_divider`, default 48: clock cycles per serial bit; legal range ≥ 2; the counter width is derived as clog2(`clk_divider`).
- `i_clk`  in  1  system clock; all logic is on the rising edge.
- `i_rst`  in  1  reset; one clock, reset synchronous and active-low (0 = reset).
- `i_data`  in  8  byte to send; sampled only on an accept edge.
- `i_valid`  in  1  send request; may be a single-cycle pulse.
- `o_ready`  out  1  1 = idle and able to accept; registered.
- `o_uart_tx`  out  1  serial line; idle high; registered.

## Operation
- Frame: 10 bits, in this order:
  - start bit 0;
  - `i_data[0]` through `i_data[7]`, LSB first;
  - stop bit 1.
- No parity; one stop bit.
- Accept: on a rising edge where `i_rst`=1, `i_valid`=1 and `o_ready`=1:
  - latch `i_data` into the shift register;
  - clear `o_ready`;
  - drive the start bit.
- `i_valid` while `o_ready`=0 is ignored. The byte is dropped, there is no error flag, and the in-flight frame is not disturbed.
- State machine:
  - IDLE: `o_uart_tx`=1, `o_ready`=1. Goes to SEND on accept.
  - SEND: a bit index 0..9 and a baud counter 0..`clk_divider`-1.
    - The baud counter increments every cycle.
    - When the counter reaches `clk_divider`-1, it wraps to 0 and the bit index advances.
    - When the counter wraps at bit index 9, the block goes to IDLE.
- `i_data` changes after accept have no effect on the frame.
- Reset (`i_rst`=0 on any edge, including mid-frame):
  - next values: `o_uart_tx`=1, `o_ready`=1, state IDLE;
  - counters and shift register are cleared;
  - a partially sent frame is abandoned.
- Reset takes priority over a simultaneous `i_valid`.

## Timing
- Notation: accept at edge E, D = `clk_divider`.
- Bit k (0 = start, 9 = stop) is on `o_uart_tx` for exactly D cycles, from after edge E+k·D through edge E+(k+1)·D.
- Total busy time is 10·D cycles:
  - `o_ready`=0 from after edge E through edge E+10·D;
  - `o_ready`=1 after edge E+10·D.
- `o_uart_tx` stays 1 from the stop bit into idle with no glitch.
- Back-to-back frames: the earliest next accept is edge E+10·D+1. The next start bit then follows exactly 10·D+1 cycles after the previous start bit began, giving a stop bit of D+1 cycles.
- Reset values: `o_ready`=1, `o_uart_tx`=1.
- Both outputs are registered: there is no combinational path from `i_valid` or `i_data` to any output.
- Baud rate is clock/D (for example, 16 MHz / 48 ≈ 333 kbaud). There is no fractional division.

## Test plan
- Reset: hold `i_rst`=0 for 3 cycles with `i_valid`=1 → `o_ready`=1 and `o_uart_tx`=1 throughout; no frame starts.
- Single byte, D=4, send 0x55 with a 1-cycle valid:
  - `o_ready` falls the next cycle;
  - TX sequence 0,1,0,1,0,1,0,1,0,1, each bit held exactly 4 cycles;
  - `o_ready` returns 1 after 40 cycles.
- Default D=48, send 0xA3: the sampled bit centres read 0,1,1,0,0,0,1,0,1,1, and 0xA3 is recovered by a bench receiver.
- Busy drop: during a frame of 0x0F, pulse `i_valid` with 0xFF → the frame is still 0x0F and no second frame is sent; `o_ready` rises once after 10·D cycles.
- Back-to-back: hold `i_valid`=1 with 0x41 then 0x42 → two frames are sent, and the second start bit begins exactly 10·D+1 cycles after the first.
- Mid-frame reset: assert `i_rst`=0 during bit 4 → TX is 1 and `o_ready`=1 after that edge; a new 0x7E sent after release is a clean, correct frame.

Source files
------------

// File: rtl/emitter_uart.sv
// Transmit-only 8N1 UART serializer: one byte in flight, fixed baud of clock/clk_divider.
// Outputs are registered; a write strobe while busy is silently dropped.
module emitter_uart #(
   parameter int clk_divider = 48
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_uart_tx
);

   localparam int CNT_W = (clk_divider > 2) ? $clog2(clk_divider) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clk_divider - 1);
   localparam logic [3:0]       IDX_STOP = 4'd9;

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       idx_q, idx_d;
   logic [8:0]       shift_q, shift_d;
   logic             ready_q, ready_d;
   logic             tx_q, tx_d;

   // The shift register holds data bits then the stop bit; tx_q is loaded one bit ahead
   // of the shift so the line changes exactly on the baud-counter wrap.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      ready_d = ready_q;
      tx_d    = tx_q;

      case (state_q)
         ST_IDLE: begin
            ready_d = 1'b1;
            tx_d    = 1'b1;
            if (i_valid) begin
               state_d = ST_SEND;
               cnt_d   = '0;
               idx_d   = '0;
               shift_d = {1'b1, i_data};
               ready_d = 1'b0;
               tx_d    = 1'b0;
            end
         end

         ST_SEND: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_STOP) begin
                  state_d = ST_IDLE;
                  idx_d   = '0;
                  shift_d = '0;
                  ready_d = 1'b1;
                  tx_d    = 1'b1;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b1, shift_q[8:1]};
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: the synchronous reset clears the whole datapath, shift register included,
   // so an abandoned frame leaves nothing behind; it also overrides a same-cycle i_valid.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      if (!i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         ready_q <= 1'b1;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         ready_q <= ready_d;
         tx_q    <= tx_d;
      end
   end

   assign o_ready   = ready_q;
   assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_emitter_uart.sv
// Self-checking bench for emitter_uart: a D=4 instance checked cycle by cycle and a
// default D=48 instance decoded by a bit-centre receiver against an expected-byte queue.
module tb_emitter_uart;

   localparam int DA = 4;
   localparam int DB = 48;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, valid_a, ready_a, tx_a;
   logic [7:0] data_a;
   logic       rst_b, valid_b, ready_b, tx_b;
   logic [7:0] data_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] sb_q[$];
   logic       exp_tx_q[$];
   int         mon_frames = 0;
   logic [9:0] mon_bits   = '0;

   emitter_uart #(.clk_divider(DA)) dut_a (
      .i_clk    (clk),
      .i_rst    (rst_a),
      .i_data   (data_a),
      .i_valid  (valid_a),
      .o_ready  (ready_a),
      .o_uart_tx(tx_a)
   );

   emitter_uart dut_b (
      .i_clk    (clk),
      .i_rst    (rst_b),
      .i_data   (data_b),
      .i_valid  (valid_b),
      .o_ready  (ready_b),
      .o_uart_tx(tx_b)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Receiver for dut_b: detect start, sample each bit centre, compare with the queue.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_b === 1'b1 && tx_b === 1'b0) begin
            logic [9:0] bits;
            logic [7:0] got;
            logic [7:0] exp;
            bits = '0;
            repeat (DB / 2) @(negedge clk);
            bits[0] = tx_b;
            for (int k = 1; k < 10; k++) begin
               repeat (DB) @(negedge clk);
               bits[k] = tx_b;
            end
            mon_bits = bits;
            got = bits[8:1];
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL rx_unexpected_frame: got byte %02h, none expected", got);
            end else begin
               exp = sb_q.pop_front();
               if (got !== exp || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
                  errors++;
                  $display("FAIL rx_frame: got bits %b (byte %02h), expected byte %02h", bits, got, exp);
               end
            end
            mon_frames++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Sends one byte on dut_a with a 1-cycle strobe and checks every TX cycle; call at a negedge.
   task automatic send_check_a(input logic [7:0] b);
      logic [9:0] frame;
      logic       exp;
      frame = {1'b1, b, 1'b0};
      checks++;
      if (ready_a !== 1'b1) begin
         errors++;
         $display("FAIL a_ready_before: got %b expected 1", ready_a);
      end
      for (int k = 0; k < 10; k++)
         repeat (DA) exp_tx_q.push_back(frame[k]);
      data_a  = b;
      valid_a = 1'b1;
      @(posedge clk);
      for (int n = 0; n < DA * 10; n++) begin
         @(negedge clk);
         if (n == 0) begin
            valid_a = 1'b0;
            data_a  = ~b;
         end
         exp = exp_tx_q.pop_front();
         checks++;
         if (tx_a !== exp || ready_a !== 1'b0) begin
            errors++;
            $display("FAIL a_frame_%02h cycle %0d: got tx=%b ready=%b expected tx=%b ready=0",
                     b, n, tx_a, ready_a, exp);
         end
      end
      @(negedge clk);
      checks++;
      if (ready_a !== 1'b1 || tx_a !== 1'b1) begin
         errors++;
         $display("FAIL a_ready_after: got ready=%b tx=%b expected 1 1", ready_a, tx_a);
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b0; rst_b = 1'b0;
      valid_a = 1'b1; valid_b = 1'b1;
      data_a = 8'h00; data_b = 8'h00;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (ready_a !== 1'b1 || tx_a !== 1'b1 || ready_b !== 1'b1 || tx_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: got a=%b%b b=%b%b expected ready/tx all 1",
                     ready_a, tx_a, ready_b, tx_b);
         end
      end
      valid_a = 1'b0; valid_b = 1'b0;
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (ready_a !== 1'b1 || tx_a !== 1'b1 || ready_b !== 1'b1 || tx_b !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got a=%b%b b=%b%b expected ready/tx all 1",
                  ready_a, tx_a, ready_b, tx_b);
      end
   endtask

   task automatic test_single_d4();
      send_check_a(8'h55);
   endtask

   task automatic test_default_a3();
      int         f0;
      int         centres[10];
      logic [9:0] exp_bits;
      centres = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1};
      for (int k = 0; k < 10; k++) exp_bits[k] = centres[k][0];
      f0 = mon_frames;
      sb_q.push_back(8'hA3);
      data_b = 8'hA3; valid_b = 1'b1;
      @(negedge clk);
      valid_b = 1'b0;
      checks++;
      if (ready_b !== 1'b0) begin
         errors++;
         $display("FAIL b_ready_fall: got %b expected 0", ready_b);
      end
      for (int i = 0; i < DB * 12 && mon_frames == f0; i++) @(negedge clk);
      checks++;
      if (mon_frames != f0 + 1) begin
         errors++;
         $display("FAIL b_a3_timeout: got %0d frames expected %0d", mon_frames - f0, 1);
      end
      checks++;
      if (mon_bits !== exp_bits) begin
         errors++;
         $display("FAIL b_a3_centres: got %b expected %b", mon_bits, exp_bits);
      end
      for (int i = 0; i < DB * 2 && ready_b !== 1'b1; i++) @(negedge clk);
   endtask

   task automatic test_busy_drop();
      int f0;
      int busy;
      int glitches;
      f0 = mon_frames;
      busy = 0;
      glitches = 0;
      sb_q.push_back(8'h0F);
      data_b = 8'h0F; valid_b = 1'b1;
      @(posedge clk);
      for (int n = 0; n < DB * 12; n++) begin
         @(negedge clk);
         if (n == 0) valid_b = 1'b0;
         if (n == 100) begin
            data_b = 8'hFF; valid_b = 1'b1;
         end
         if (n == 101) valid_b = 1'b0;
         if (ready_b === 1'b1) break;
         busy++;
      end
      checks++;
      if (busy != DB * 10) begin
         errors++;
         $display("FAIL busy_len: got %0d busy cycles expected %0d", busy, DB * 10);
      end
      for (int n = 0; n < DB * 12; n++) begin
         @(negedge clk);
         if (ready_b !== 1'b1 || tx_b !== 1'b1) glitches++;
      end
      checks++;
      if (glitches != 0) begin
         errors++;
         $display("FAIL busy_second_frame: got %0d non-idle cycles expected 0", glitches);
      end
      checks++;
      if (mon_frames != f0 + 1) begin
         errors++;
         $display("FAIL busy_frames: got %0d frames expected 1", mon_frames - f0);
      end
   endtask

   task automatic test_back_to_back();
      int f0;
      int t1;
      int t2;
      f0 = mon_frames;
      sb_q.push_back(8'h41);
      sb_q.push_back(8'h42);
      data_b = 8'h41; valid_b = 1'b1;
      @(negedge clk);
      t1 = cyc;
      checks++;
      if (ready_b !== 1'b0 || tx_b !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first_start: got ready=%b tx=%b expected 0 0", ready_b, tx_b);
      end
      data_b = 8'h42;
      for (int i = 0; i < DB * 12 && ready_b !== 1'b1; i++) @(negedge clk);
      @(negedge clk);
      t2 = cyc;
      valid_b = 1'b0;
      checks++;
      if (ready_b !== 1'b0 || tx_b !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_start: got ready=%b tx=%b expected 0 0", ready_b, tx_b);
      end
      checks++;
      if (t2 - t1 != DB * 10 + 1) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d cycles expected %0d", t2 - t1, DB * 10 + 1);
      end
      for (int i = 0; i < DB * 12 && mon_frames < f0 + 2; i++) @(negedge clk);
      checks++;
      if (mon_frames != f0 + 2) begin
         errors++;
         $display("FAIL b2b_frames: got %0d frames expected 2", mon_frames - f0);
      end
      for (int i = 0; i < DB * 2 && ready_b !== 1'b1; i++) @(negedge clk);
   endtask

   task automatic test_midframe_reset();
      logic [9:0] frame;
      int         stray;
      frame = {1'b1, 8'h33, 1'b0};
      stray = 0;
      data_a = 8'h33; valid_a = 1'b1;
      @(posedge clk);
      for (int n = 0; n <= 17; n++) begin
         @(negedge clk);
         if (n == 0) valid_a = 1'b0;
      end
      checks++;
      if (tx_a !== frame[4] || ready_a !== 1'b0) begin
         errors++;
         $display("FAIL mid_bit4: got tx=%b ready=%b expected tx=%b ready=0", tx_a, ready_a, frame[4]);
      end
      rst_a = 1'b0;
      valid_a = 1'b1; data_a = 8'hFF;
      @(negedge clk);
      checks++;
      if (tx_a !== 1'b1 || ready_a !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: got tx=%b ready=%b expected 1 1", tx_a, ready_a);
      end
      rst_a = 1'b1; valid_a = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || ready_a !== 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL mid_after_release: got %0d non-idle cycles expected 0", stray);
      end
      send_check_a(8'h7E);
   endtask

   initial begin
      test_reset();
      test_single_d4();
      test_default_a3();
      test_busy_drop();
      test_back_to_back();
      test_midframe_reset();
      repeat (4) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d bytes pending expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
